// File: rtl/display_pkg.sv
// Shared types and helpers for the score display controller.
package display_pkg;

  localparam int unsigned BCD_W = 16;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;
  typedef logic [BCD_W-1:0] bcd4_t;

  localparam logic [3:0]  DIGIT_DASH = 4'hF;
  localparam logic [13:0] MAX_SCORE  = 14'd9999;

  // Double-dabble correction: every nibble >= 5 gets +3 before the next shift.
  function automatic bcd4_t bcd_add3(input bcd4_t b);
    bcd4_t r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_shift_engine.sv
// Serial binary-to-BCD converter: one add-3/shift step per cycle, SCORE_W steps per value.
module bcd_shift_engine
  import display_pkg::*;
#(
  parameter int unsigned SCORE_W = 14
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [SCORE_W-1:0] i_value,
  output logic               o_busy,
  output logic               o_done,
  output bcd4_t              o_bcd
);

  localparam int unsigned SH_W   = BCD_W + SCORE_W;
  localparam int unsigned ITER_W = $clog2(SCORE_W + 1);

  conv_state_t       r_state;
  logic [SH_W-1:0]   r_shift;
  logic [ITER_W-1:0] r_iter;
  logic              r_busy;
  logic              r_done;
  logic [SH_W-1:0]   w_adj;

  assign w_adj  = {bcd_add3(r_shift[SH_W-1 -: BCD_W]), r_shift[SCORE_W-1:0]};
  assign o_bcd  = r_shift[SH_W-1 -: BCD_W];
  assign o_busy = r_busy;
  assign o_done = r_done;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_iter  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_shift <= {BCD_W'(0), i_value};
            r_iter  <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_shift <= {w_adj[SH_W-2:0], 1'b0};
          r_iter  <= r_iter + ITER_W'(1);
          if (r_iter == ITER_W'(SCORE_W - 1)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/score_display_ctrl.sv
// Game display sequencer: captures score/level, shares one BCD engine, and selects
// score, a timed level readout, or a blinking game-over pattern for the 4-digit display.
module score_display_ctrl
  import display_pkg::*;
#(
  parameter int unsigned SCORE_W    = 14,
  parameter int unsigned BLINK_W    = 24,
  parameter int unsigned LEVEL_HOLD = 200_000_000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [SCORE_W-1:0] i_score,
  input  logic               i_score_valid,
  input  logic [3:0]         i_level,
  input  logic               i_level_valid,
  input  logic               i_game_over,
  output logic [3:0]         o_dig0,
  output logic [3:0]         o_dig1,
  output logic [3:0]         o_dig2,
  output logic [3:0]         o_dig3,
  output logic               o_busy,
  output logic               o_done
);

  localparam int unsigned HOLD_W = $clog2(LEVEL_HOLD + 1);

  logic [SCORE_W-1:0] r_score_pend;
  logic               r_score_req;
  logic [3:0]         r_level_pend;
  logic               r_level_req;
  logic               r_conv_level;
  bcd4_t              r_score_bcd;
  logic [7:0]         r_level_bcd;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;
  bcd4_t              r_dig;

  logic               w_eng_busy;
  logic               w_eng_done;
  bcd4_t              w_eng_bcd;
  logic               w_grant_score;
  logic               w_grant_level;
  logic               w_start;
  logic [SCORE_W-1:0] w_start_value;
  logic [SCORE_W-1:0] w_score_sat;
  bcd4_t              w_score_bcd_nxt;
  logic [7:0]         w_level_bcd_nxt;
  logic [HOLD_W-1:0]  w_hold_nxt;
  logic [BLINK_W-1:0] w_blink_cnt_nxt;
  logic               w_blink_phase_nxt;
  bcd4_t              w_dig_nxt;

  assign w_score_sat   = (i_score > SCORE_W'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : i_score;
  assign w_grant_score = !w_eng_busy && r_score_req;
  assign w_grant_level = !w_eng_busy && !r_score_req && r_level_req;
  assign w_start       = w_grant_score || w_grant_level;
  assign w_start_value = w_grant_score ? r_score_pend : SCORE_W'(r_level_pend);

  bcd_shift_engine #(.SCORE_W(SCORE_W)) u_engine (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (w_start),
    .i_value (w_start_value),
    .o_busy  (w_eng_busy),
    .o_done  (w_eng_done),
    .o_bcd   (w_eng_bcd)
  );

  // Next-state of the display sources; the digit mux looks at these so a commit
  // shows up on the digits the cycle right after done.
  always_comb begin
    w_score_bcd_nxt   = r_score_bcd;
    w_level_bcd_nxt   = r_level_bcd;
    w_hold_nxt        = (r_hold_cnt != '0) ? r_hold_cnt - HOLD_W'(1) : '0;
    w_blink_cnt_nxt   = '0;
    w_blink_phase_nxt = 1'b1;
    w_dig_nxt         = '0;

    if (w_eng_done) begin
      if (r_conv_level) begin
        w_level_bcd_nxt = w_eng_bcd[7:0];
        w_hold_nxt      = HOLD_W'(LEVEL_HOLD);
      end else begin
        w_score_bcd_nxt = w_eng_bcd;
      end
    end

    if (i_game_over) begin
      w_blink_cnt_nxt   = r_blink_cnt + BLINK_W'(1);
      w_blink_phase_nxt = (&r_blink_cnt) ? !r_blink_phase : r_blink_phase;
    end

    if (i_game_over) begin
      w_dig_nxt = w_blink_phase_nxt ? w_score_bcd_nxt : {4{DIGIT_DASH}};
    end else if (w_hold_nxt != '0) begin
      w_dig_nxt = {DIGIT_DASH, DIGIT_DASH, w_level_bcd_nxt};
    end else begin
      w_dig_nxt = w_score_bcd_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_score_pend  <= '0;
      r_score_req   <= 1'b0;
      r_level_pend  <= '0;
      r_level_req   <= 1'b0;
      r_conv_level  <= 1'b0;
      r_score_bcd   <= '0;
      r_level_bcd   <= '0;
      r_hold_cnt    <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
      r_dig         <= '0;
    end else begin
      if (w_grant_score) r_score_req <= 1'b0;
      if (w_grant_level) r_level_req <= 1'b0;
      if (w_start)       r_conv_level <= w_grant_level;
      // Captures come after the grant clears so a same-cycle update stays pending.
      if (i_score_valid) begin
        r_score_pend <= w_score_sat;
        r_score_req  <= 1'b1;
      end
      if (i_level_valid) begin
        r_level_pend <= i_level;
        r_level_req  <= 1'b1;
      end
      r_score_bcd   <= w_score_bcd_nxt;
      r_level_bcd   <= w_level_bcd_nxt;
      r_hold_cnt    <= w_hold_nxt;
      r_blink_cnt   <= w_blink_cnt_nxt;
      r_blink_phase <= w_blink_phase_nxt;
      r_dig         <= w_dig_nxt;
    end
  end

  assign o_dig0 = r_dig[3:0];
  assign o_dig1 = r_dig[7:4];
  assign o_dig2 = r_dig[11:8];
  assign o_dig3 = r_dig[15:12];
  assign o_busy = w_eng_busy;
  assign o_done = w_eng_done;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed plus randomized checks of score_display_ctrl against decimal-arithmetic expectations.
module tb_score_display_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] score;
  logic        score_valid;
  logic [3:0]  level;
  logic        level_valid;
  logic        game_over;
  logic [3:0]  dig0, dig1, dig2, dig3;
  logic        busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  score_display_ctrl #(.SCORE_W(14), .BLINK_W(3), .LEVEL_HOLD(20)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_score       (score),
    .i_score_valid (score_valid),
    .i_level       (level),
    .i_level_valid (level_valid),
    .i_game_over   (game_over),
    .o_dig0        (dig0),
    .o_dig1        (dig1),
    .o_dig2        (dig2),
    .o_dig3        (dig3),
    .o_busy        (busy),
    .o_done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] dec4(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] lvl_disp(input int l);
    return {8'hFF, 4'(l / 10), 4'(l % 10)};
  endfunction

  function automatic logic [15:0] digs();
    return {dig3, dig2, dig1, dig0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input bit do_score, input int sv, input bit do_level, input int lv);
    score       = 14'(sv);
    level       = 4'(lv);
    score_valid = do_score;
    level_valid = do_level;
    step();
    score_valid = 1'b0;
    level_valid = 1'b0;
  endtask

  // Returns the cycle number of the next done pulse, or -1 if none within budget.
  task automatic wait_done(output int t);
    t = -1;
    for (int i = 0; i < 64; i++) begin
      step();
      if (done === 1'b1) begin
        t = cyc;
        break;
      end
    end
  endtask

  initial begin
    int t0, t1, t2, v, l, ndone, last_score;
    bit show;

    reset = 1'b1; score = '0; score_valid = 1'b0; level = '0; level_valid = 1'b0; game_over = 1'b0;
    repeat (3) step();
    chk("reset_dig", digs(), 16'h0000);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    reset = 1'b0;

    // Basic conversion and latency
    t0 = cyc;
    pulse(1, 1234, 0, 0);
    step();
    chk("busy_during_conv", busy, 1'b1);
    wait_done(t1);
    chk("lat_1234", t1 - t0, 16);
    step();
    chk("dig_1234", digs(), 16'h1234);
    chk("done_width", done, 1'b0);
    chk("busy_after", busy, 1'b0);

    // Saturation
    t0 = cyc;
    pulse(1, 12000, 0, 0);
    wait_done(t1);
    chk("lat_sat", t1 - t0, 16);
    step();
    chk("dig_sat", digs(), 16'h9999);

    // Simultaneous score and level: score first, level next
    t0 = cyc;
    pulse(1, 42, 1, 7);
    wait_done(t1);
    chk("lat_both_first", t1 - t0, 16);
    step();
    chk("dig_both_score", digs(), 16'h0042);
    wait_done(t2);
    chk("lat_both_second", t2 - t1, 16);
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("level_hold_%0d", k), digs(), 16'hFF07);
    end
    step();
    chk("after_hold", digs(), 16'h0042);

    // Overwrites during a conversion collapse to one further conversion
    pulse(1, 100, 0, 0);
    ndone = 0;
    repeat (2) begin step(); ndone += int'(done); end
    pulse(1, 5, 0, 0);
    step(); ndone += int'(done);
    pulse(1, 6, 0, 0);
    step(); ndone += int'(done);
    pulse(1, 77, 0, 0);
    for (int i = 0; i < 60; i++) begin
      step();
      ndone += int'(done);
    end
    chk("overwrite_done_count", ndone, 2);
    chk("overwrite_dig", digs(), 16'h0077);

    // Game-over blink with score 0815
    pulse(1, 815, 0, 0);
    wait_done(t1);
    step();
    chk("dig_0815", digs(), 16'h0815);
    game_over = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      show = ((k / 8) % 2) == 0;
      chk($sformatf("blink_%0d", k), digs(), show ? 16'h0815 : 16'hFFFF);
    end
    game_over = 1'b0;
    step();
    chk("blink_off", digs(), 16'h0815);
    repeat (9) step();
    chk("blink_off_steady", digs(), 16'h0815);

    // Randomized scores
    last_score = 815;
    for (int i = 0; i < 8; i++) begin
      v = int'($urandom_range(0, 16383));
      t0 = cyc;
      pulse(1, v, 0, 0);
      wait_done(t1);
      chk($sformatf("rnd_lat_%0d", i), t1 - t0, 16);
      step();
      chk($sformatf("rnd_score_%0d_v%0d", i, v), digs(), dec4(v));
      last_score = v;
    end

    // Randomized levels, each followed by a return to the score
    for (int i = 0; i < 4; i++) begin
      l = int'($urandom_range(0, 15));
      t0 = cyc;
      pulse(0, 0, 1, l);
      wait_done(t1);
      chk($sformatf("rnd_lvl_lat_%0d", i), t1 - t0, 16);
      step();
      chk($sformatf("rnd_level_%0d_l%0d", i, l), digs(), lvl_disp(l));
      repeat (20) step();
      chk($sformatf("rnd_level_ret_%0d", i), digs(), dec4(last_score));
    end

    // Reset in the middle of a conversion
    pulse(1, 4321, 0, 0);
    repeat (4) step();
    chk("pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    step();
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_done", done, 1'b0);
    chk("midreset_dig", digs(), 16'h0000);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      ndone += int'(done);
    end
    chk("midreset_no_done", ndone, 0);
    chk("midreset_dig_late", digs(), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
